abc_pattern_sequencer: RTL and testbench

Upstream stimulus stage for the 3-bit case decoder: generates the select vector {a,b,c} as a fixed five-step pattern, holding each step for a programmable number of clock cycles. It replaces hand-written initial-block delays with a synthesizable, restartable sequencer. Outputs drive the decoder's a, b and c inputs directly, with a valid/busy/done handshake toward the controlling logic.

---
 rtl/abc_seq_pkg.sv | 27 ++
 rtl/abc_hold_counter.sv | 28 ++
 rtl/abc_pattern_sequencer.sv | 114 +++++++++++
 tb/tb_abc_pattern_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/abc_seq_pkg.sv
// Shared types and constants for the {a,b,c} pattern sequencer.
// Holds the FSM state encoding and the five-step select pattern.
package abc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_STEPS = 5;
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  // Step 0 sits in the least significant three bits.
  localparam logic [3*NUM_STEPS-1:0] PATTERN_TBL = {3'b110, 3'b000, 3'b101, 3'b001, 3'b000};

  function automatic logic [2:0] pattern_at(input logic [2:0] idx);
    logic [2:0] v;
    v = 3'b000;
    for (int i = 0; i < NUM_STEPS; i++) begin
      if (idx == 3'(i)) v = PATTERN_TBL[i*3 +: 3];
    end
    return v;
  endfunction

endpackage

// File: rtl/abc_hold_counter.sv
// Per-step hold counter: counts 0..HOLD_CYCLES-1 while enabled, flags the last cycle.
// Clear has priority over enable.
module abc_hold_counter #(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/abc_pattern_sequencer.sv
// Drives {a,b,c} through a fixed five-step pattern, each step held HOLD_CYCLES cycles.
// Restartable from IDLE, optional looping, level pause; all outputs registered.
module abc_pattern_sequencer
  import abc_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 10,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       loop_en,
  input  logic       pause,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] step_idx,
  output logic       sel_valid,
  output logic       busy,
  output logic       done
);

  state_t     r_state;
  logic [2:0] r_step;
  logic [2:0] r_abc;
  logic       r_sel_valid;
  logic       r_busy;
  logic       r_done;

  logic       w_active;
  logic       w_go;
  logic       w_count;
  logic       w_tc;
  logic       w_last;
  logic [2:0] w_step_inc;

  assign w_active   = (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign w_go       = (r_state == ST_IDLE) && start;
  // A cycle without pause counts even when leaving PAUSED, so each paused cycle adds exactly one.
  assign w_count    = w_active && !pause;
  assign w_last     = (r_step == LAST_STEP);
  assign w_step_inc = r_step + 3'd1;

  abc_hold_counter #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_hold_counter (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_go || (w_count && w_tc)),
    .i_en (w_count && !w_tc),
    .o_tc (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= 3'd0;
      r_abc       <= 3'b000;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_RUN;
            r_step      <= 3'd0;
            r_abc       <= pattern_at(3'd0);
            r_sel_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            r_state <= ST_PAUSED;
          end else if (!w_tc) begin
            r_state <= ST_RUN;
          end else if (!w_last) begin
            r_state <= ST_RUN;
            r_step  <= w_step_inc;
            r_abc   <= pattern_at(w_step_inc);
          end else if (loop_en) begin
            r_state <= ST_RUN;
            r_step  <= 3'd0;
            r_abc   <= pattern_at(3'd0);
          end else begin
            // Last hold cycle of a one-shot run: step and pattern stay visible while idle.
            r_state     <= ST_DONE;
            r_sel_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a         = r_abc[2];
  assign b         = r_abc[1];
  assign c         = r_abc[0];
  assign step_idx  = r_step;
  assign sel_valid = r_sel_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_abc_pattern_sequencer.sv
// Directed bench: three sequencer instances (HOLD_CYCLES = 3, 2, 1) share inputs;
// each scenario resets, drives one instance's case and checks its outputs.
module tb_abc_pattern_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic loop_en;
  logic pause;

  logic       a3, b3, c3, v3, bz3, d3;
  logic [2:0] s3;
  logic       a2, b2, c2, v2, bz2, d2;
  logic [2:0] s2;
  logic       a1, b1, c1, v1, bz1, d1;
  logic [2:0] s1;

  logic [8:0] o3, o2, o1;
  assign o3 = {a3, b3, c3, s3, v3, bz3, d3};
  assign o2 = {a2, b2, c2, s2, v2, bz2, d2};
  assign o1 = {a1, b1, c1, s1, v1, bz1, d1};

  int tests = 0;
  int fails = 0;
  logic [2:0] pat [5];

  always #5 clk = ~clk;

  abc_pattern_sequencer #(.HOLD_CYCLES(3), .CNT_W(8)) u_h3 (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .pause(pause),
    .a(a3), .b(b3), .c(c3), .step_idx(s3), .sel_valid(v3), .busy(bz3), .done(d3)
  );

  abc_pattern_sequencer #(.HOLD_CYCLES(2), .CNT_W(8)) u_h2 (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .pause(pause),
    .a(a2), .b(b2), .c(c2), .step_idx(s2), .sel_valid(v2), .busy(bz2), .done(d2)
  );

  abc_pattern_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
    .clk(clk), .rst(rst), .start(start), .loop_en(loop_en), .pause(pause),
    .a(a1), .b(b1), .c(c1), .step_idx(s1), .sel_valid(v1), .busy(bz1), .done(d1)
  );

  function automatic logic [8:0] mk(input logic [2:0] abc, input int step,
                                    input logic v, input logic bz, input logic d);
    return {abc, 3'(step), v, bz, d};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed abc/step/vld/busy/done=%b expected %b", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; loop_en = 1'b0; pause = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int st;
    pat[0] = 3'b000; pat[1] = 3'b001; pat[2] = 3'b101; pat[3] = 3'b000; pat[4] = 3'b110;

    // 1: reset state, then a one-shot run with HOLD_CYCLES=3
    do_reset();
    chk("t1 reset", o3, mk(3'b000, 0, 0, 0, 0));
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("t1 cyc%0d", i), o3, mk(pat[i/3], i/3, 1, 1, 0));
      tick();
    end
    chk("t1 done", o3, mk(3'b110, 4, 0, 0, 1));
    tick();
    chk("t1 idle hold", o3, mk(3'b110, 4, 0, 0, 0));
    tick();
    chk("t1 idle stay", o3, mk(3'b110, 4, 0, 0, 0));

    // 2: looping with HOLD_CYCLES=2 wraps to step 0 without done
    do_reset();
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("t2 cyc%0d", i), o2, mk(pat[(i/2)%5], (i/2)%5, 1, 1, 0));
      tick();
    end

    // 3: pause for four cycles during step 1 (HOLD_CYCLES=3)
    do_reset();
    pulse_start();
    for (int i = 0; i < 19; i++) begin
      st = (i < 3) ? 0 : (i < 10) ? 1 : 2 + (i - 10) / 3;
      pause = (i >= 4 && i <= 7);
      chk($sformatf("t3 cyc%0d", i), o3, mk(pat[st], st, 1, 1, 0));
      tick();
    end
    pause = 1'b0;
    chk("t3 done", o3, mk(3'b110, 4, 0, 0, 1));

    // 4: start ignored mid-run and in DONE; restart from first IDLE cycle
    do_reset();
    pulse_start();
    for (int i = 0; i < 15; i++) begin
      start = (i == 7);
      chk($sformatf("t4 cyc%0d", i), o3, mk(pat[i/3], i/3, 1, 1, 0));
      tick();
    end
    start = 1'b1;
    chk("t4 done", o3, mk(3'b110, 4, 0, 0, 1));
    tick();
    start = 1'b0;
    chk("t4 idle after done", o3, mk(3'b110, 4, 0, 0, 0));
    pulse_start();
    chk("t4 restart step0", o3, mk(3'b000, 0, 1, 1, 0));
    tick(); tick(); tick();
    chk("t4 restart step1", o3, mk(3'b001, 1, 1, 1, 0));

    // 5: asynchronous reset in step 3
    do_reset();
    pulse_start();
    repeat (10) tick();
    chk("t5 in step3", o3, mk(3'b000, 3, 1, 1, 0));
    #2;
    rst = 1'b1;
    #1;
    chk("t5 async reset", o3, mk(3'b000, 0, 0, 0, 0));
    tick();
    chk("t5 reset held", o3, mk(3'b000, 0, 0, 0, 0));
    rst = 1'b0;
    tick();
    chk("t5 no done", o3, mk(3'b000, 0, 0, 0, 0));
    pulse_start();
    chk("t5 rerun step0", o3, mk(3'b000, 0, 1, 1, 0));
    tick(); tick(); tick();
    chk("t5 rerun step1", o3, mk(3'b001, 1, 1, 1, 0));

    // 6: HOLD_CYCLES=1 advances every cycle, done on the sixth cycle
    do_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t6 cyc%0d", i), o1, mk(pat[i], i, 1, 1, 0));
      tick();
    end
    chk("t6 done", o1, mk(3'b110, 4, 0, 0, 1));
    tick();
    chk("t6 idle", o1, mk(3'b110, 4, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
